// File: rtl/sfm_pkg.sv
// rtl/sfm_pkg.sv - shared types and constants for the softmax streamer blocks
package sfm_pkg;

  localparam int SFM_BEAT_CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    ZERO
  } sfm_realign_state_e;

endpackage

// File: rtl/sfm_byte_shifter.sv
// rtl/sfm_byte_shifter.sv - combinational byte-granular barrel shifter
module sfm_byte_shifter
  import sfm_pkg::*;
#(
  parameter int unsigned NB    = 16,
  parameter int unsigned AMT_W = 4
) (
  input  logic [8*NB-1:0] data_i,
  input  logic [AMT_W-1:0] amt_i,
  input  logic             left_i,
  output logic [8*NB-1:0] data_o
);

  logic [AMT_W+2:0] bit_amt;

  assign bit_amt = {amt_i, 3'b000};
  assign data_o  = left_i ? (data_i << bit_amt) : (data_i >> bit_amt);

endmodule

// File: rtl/sfm_stream_realigner.sv
// rtl/sfm_stream_realigner.sv - compacts strobed, unaligned load beats into
// dense byte-0-aligned beats with a partial strobed tail
module sfm_stream_realigner
  import sfm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 128
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    start_i,
  input  logic [31:0]             num_beats_i,
  input  logic [DATA_WIDTH-1:0]   in_stream_data_i,
  input  logic [DATA_WIDTH/8-1:0] in_stream_strb_i,
  input  logic                    in_stream_valid_i,
  output logic                    in_stream_ready_o,
  output logic [DATA_WIDTH-1:0]   out_stream_data_o,
  output logic [DATA_WIDTH/8-1:0] out_stream_strb_o,
  output logic                    out_stream_valid_o,
  input  logic                    out_stream_ready_i,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int unsigned BW = DATA_WIDTH / 8;
  localparam int unsigned CW = $clog2(BW);

  sfm_realign_state_e state_q, state_d;

  logic [SFM_BEAT_CNT_W-1:0] beat_cnt_q, num_beats_q;
  logic [DATA_WIDTH-1:0]     hold_q;
  logic [CW-1:0]             hold_cnt_q;
  logic [DATA_WIDTH-1:0]     out_data_q;
  logic [BW-1:0]             out_strb_q;
  logic                      out_valid_q, out_last_q, done_pend_q;

  logic                      out_free, in_hs, is_last, full, flush_go;
  logic [DATA_WIDTH-1:0]     masked, aligned;
  logic [2*DATA_WIDTH-1:0]   shifted, combined;
  logic [CW-1:0]             lead, new_hold_cnt;
  logic [CW:0]               n, sum;

  assign out_free          = !out_valid_q || out_stream_ready_i;
  assign in_stream_ready_o = (state_q == RUN) && out_free;
  assign in_hs             = in_stream_valid_i && in_stream_ready_o;
  assign is_last           = beat_cnt_q == (num_beats_q - SFM_BEAT_CNT_W'(1));
  assign flush_go          = (state_q == FLUSH) && out_free;

  // Invalid bytes are zeroed up front so the combine vector only ever ORs real data.
  always_comb begin
    masked = '0;
    lead   = '0;
    n      = '0;
    for (int i = 0; i < int'(BW); i++) begin
      masked[8*i +: 8] = in_stream_data_i[8*i +: 8] & {8{in_stream_strb_i[i]}};
      n = n + (CW+1)'(in_stream_strb_i[i]);
    end
    for (int i = int'(BW) - 1; i >= 0; i--) begin
      if (in_stream_strb_i[i]) lead = CW'(i);
    end
  end

  sfm_byte_shifter #(.NB(BW), .AMT_W(CW)) u_lead_shift (
    .data_i (masked),
    .amt_i  (lead),
    .left_i (1'b0),
    .data_o (aligned)
  );

  sfm_byte_shifter #(.NB(2*BW), .AMT_W(CW)) u_hold_shift (
    .data_i ({{DATA_WIDTH{1'b0}}, aligned}),
    .amt_i  (hold_cnt_q),
    .left_i (1'b1),
    .data_o (shifted)
  );

  assign combined     = shifted | {{DATA_WIDTH{1'b0}}, hold_q};
  assign sum          = {1'b0, hold_cnt_q} + n;
  assign full         = sum[CW];
  assign new_hold_cnt = sum[CW-1:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = (num_beats_i != '0) ? RUN : ZERO;
      RUN:     if (in_hs && is_last) state_d = (new_hold_cnt != '0) ? FLUSH : IDLE;
      FLUSH:   if (out_free) state_d = IDLE;
      ZERO:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      num_beats_q <= '0;
      hold_q      <= '0;
      hold_cnt_q  <= '0;
      out_data_q  <= '0;
      out_strb_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_pend_q <= 1'b0;
      if (state_q == IDLE && start_i && num_beats_i != '0) begin
        num_beats_q <= num_beats_i;
        beat_cnt_q  <= '0;
        hold_cnt_q  <= '0;
        hold_q      <= '0;
      end
      if (out_valid_q && out_stream_ready_i) out_valid_q <= 1'b0;
      if (in_hs) begin
        beat_cnt_q <= beat_cnt_q + SFM_BEAT_CNT_W'(1);
        hold_cnt_q <= new_hold_cnt;
        if (full) begin
          out_data_q  <= combined[DATA_WIDTH-1:0];
          out_strb_q  <= '1;
          out_valid_q <= 1'b1;
          out_last_q  <= is_last && (new_hold_cnt == '0);
          hold_q      <= combined[2*DATA_WIDTH-1:DATA_WIDTH];
        end else begin
          hold_q <= combined[DATA_WIDTH-1:0];
        end
        // A run that ends with nothing to emit still owes its done pulse.
        if (is_last && !full && new_hold_cnt == '0) done_pend_q <= 1'b1;
      end
      if (flush_go) begin
        out_data_q  <= hold_q;
        out_strb_q  <= ~({BW{1'b1}} << hold_cnt_q);
        out_valid_q <= 1'b1;
        out_last_q  <= 1'b1;
        hold_cnt_q  <= '0;
        hold_q      <= '0;
      end
    end
  end

  assign out_stream_data_o  = out_data_q;
  assign out_stream_strb_o  = out_strb_q;
  assign out_stream_valid_o = out_valid_q;
  assign busy_o             = (state_q != IDLE) || out_valid_q;
  assign done_o             = (state_q == ZERO) || done_pend_q ||
                              (out_valid_q && out_stream_ready_i && out_last_q);

endmodule
